// File: rtl/cla_pkg.sv
// Shared types and constants for the arbitrated 64-bit carry-lookahead adder.
package cla_pkg;
  localparam int CLA_W       = 64;
  localparam int CLA_IDW_MAX = 3;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  typedef struct packed {
    logic [CLA_W-1:0]       sum;
    logic                   cout;
    logic                   ovf;
    logic [CLA_IDW_MAX-1:0] id;
  } cla_rsp_t;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction
endpackage

// File: rtl/cla_64bit.sv
// 64-bit adder built from 4-bit carry-lookahead groups with rippled group carries.
module cla_64bit
  import cla_pkg::*;
(
  input  logic [CLA_W-1:0] in_a,
  input  logic [CLA_W-1:0] in_b,
  input  logic             in_cin,
  output logic [CLA_W-1:0] out_sum,
  output logic             out_overflow
);
  logic [CLA_W-1:0] w_g;
  logic [CLA_W-1:0] w_p;
  logic [CLA_W:0]   w_c;

  assign w_g    = in_a & in_b;
  assign w_p    = in_a ^ in_b;
  assign w_c[0] = in_cin;

  for (genvar gi = 0; gi < CLA_W/4; gi++) begin : g_grp
    localparam int B = 4*gi;
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_c[B]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_c[B]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    assign w_c[B+4] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                    | (&w_p[B+3:B] & w_c[B]);
  end

  assign out_sum      = w_p ^ w_c[CLA_W-1:0];
  assign out_overflow = w_c[CLA_W] ^ w_c[CLA_W-1];
endmodule

// File: rtl/cla_rr_arb.sv
// Combinational round-robin arbiter; searches upward from ptr+1, or pins to lock_id when locked.
module cla_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_lock_en,
  input  logic [IDW-1:0]  i_lock_id,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);
  int   w_cand;
  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    if (i_lock_en) begin
      // A locked requester that drops valid stalls everyone else.
      if (i_req[i_lock_id]) begin
        o_grant[i_lock_id] = 1'b1;
        o_idx              = i_lock_id;
      end
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        w_cand = (int'(i_ptr) + k) % NREQ;
        if (!w_found && i_req[w_cand]) begin
          w_found          = 1'b1;
          o_grant[w_cand]  = 1'b1;
          o_idx            = IDW'(w_cand);
        end
      end
    end
  end
endmodule

// File: rtl/cla_add_arbiter.sv
// Round-robin sharing of one cla_64bit between NREQ requesters with a registered response slot.
// Optional carry-chained lock mode: define CLA_ADD_ARB_LOCK_EN.
module cla_add_arbiter
  import cla_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*CLA_W-1:0] req_a,
  input  logic [NREQ*CLA_W-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_last,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CLA_W-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic [IDW-1:0]        rsp_id
);
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gidx;
  logic             w_slot_free;
  logic             w_xfer;
  logic             w_lock_en;
  logic             w_cin;
  logic             w_cout;
  logic             w_ovf;
  logic [CLA_W-1:0] w_a;
  logic [CLA_W-1:0] w_b;
  logic [CLA_W-1:0] w_sum;

  logic [IDW-1:0]   r_ptr;
  logic             r_rsp_valid;
  cla_rsp_t         r_rsp;

  cla_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .i_lock_en (w_lock_en),
    .i_lock_id (r_ptr),
    .o_grant   (w_grant),
    .o_idx     (w_gidx)
  );

  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign req_ready   = w_slot_free ? w_grant : '0;
  assign w_xfer      = w_slot_free && (|w_grant);
  assign w_a         = req_a[w_gidx*CLA_W +: CLA_W];
  assign w_b         = req_b[w_gidx*CLA_W +: CLA_W];

`ifdef CLA_ADD_ARB_LOCK_EN
  arb_state_t r_state;
  logic       r_chain_c;

  // The lock id is r_ptr: the locked requester was the last one granted.
  assign w_lock_en = (r_state == ARB_LOCKED);
  assign w_cin     = w_lock_en ? r_chain_c : req_cin[w_gidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_chain_c <= 1'b0;
    end else if (w_xfer) begin
      r_chain_c <= w_cout;
      case (r_state)
        ARB_IDLE:   if (!req_last[w_gidx]) r_state <= ARB_LOCKED;
        ARB_LOCKED: if (req_last[w_gidx])  r_state <= ARB_IDLE;
        default:    r_state <= ARB_IDLE;
      endcase
    end
  end
`else
  assign w_lock_en = 1'b0;
  assign w_cin     = req_cin[w_gidx];
`endif

  cla_64bit u_add (
    .in_a         (w_a),
    .in_b         (w_b),
    .in_cin       (w_cin),
    .out_sum      (w_sum),
    .out_overflow (w_ovf)
  );

  // The adder exposes no carry-out; recover it from the bit-63 carry-in.
  assign w_cout = maj(w_a[CLA_W-1], w_b[CLA_W-1], w_sum[CLA_W-1] ^ w_a[CLA_W-1] ^ w_b[CLA_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
      r_ptr       <= IDW'(NREQ-1);
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp.sum   <= w_sum;
      r_rsp.cout  <= w_cout;
      r_rsp.ovf   <= w_ovf;
      r_rsp.id    <= CLA_IDW_MAX'(w_gidx);
      r_ptr       <= w_gidx;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp.sum;
  assign rsp_cout  = r_rsp.cout;
  assign rsp_ovf   = r_rsp.ovf;
  assign rsp_id    = r_rsp.id[IDW-1:0];
endmodule

// File: doc/cla_add_arbiter.md
# cla_add_arbiter

- Shares one `cla_64bit` adder between `NREQ` requesters using round-robin arbitration.
- Each accepted request adds `a + b + cin` in one cycle and returns sum, carry-out, signed overflow and requester id through a single registered response slot with valid/ready handshake.
- An optional lock mode chains carry across consecutive beats from one requester, giving multi-word (128/256-bit) adds.
- Sits between the execution-unit requesters and the shared 64-bit adder.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `IDW`, `$clog2(NREQ)`, width of `rsp_id`.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`  in  NREQ*64  operand A; requester i at bits [64i+63:64i].
- `req_b`  in  NREQ*64  operand B, same packing.
- `req_cin`  in  NREQ  carry-in per requester.
- `req_last`  in  NREQ  final beat of a chained add (used only with lock mode).
- `rsp_valid`  out  1  response slot full.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_sum`  out  64  registered sum.
- `rsp_cout`  out  1  carry out of bit 63.
- `rsp_ovf`  out  1  two's-complement overflow (adder `out_overflow`).
- `rsp_id`  out  IDW  index of the requester that produced the response.

## Operation
- **Slot free:** `slot_free = !rsp_valid || rsp_ready`.
- **Grant:** the first requester with `req_valid` high, searching upward from `ptr+1` and wrapping modulo `NREQ`.
- **Accept:** `req_ready[g]` is asserted combinationally only when `slot_free` is high. All other `req_ready` bits are 0.
- **Transfer:** happens on the edge where `req_valid[g] && req_ready[g]`. On that edge:
  - the response registers load the new result;
  - `rsp_id` ← g;
  - `ptr` ← g.
- **Carry-out:** not a `cla_64bit` port. Compute it from bit 63 as `cout = maj(a63, b63, s63 ^ a63 ^ b63)`.
- **Response slot:**
  - `rsp_valid` sets on a transfer.
  - It clears on `rsp_ready` when no new transfer happens in the same cycle.
  - Drain and refill in the same cycle keeps `rsp_valid` high and loads the new data.
- **Requester rule:** requesters hold valid and operands stable until accepted. Retraction is a protocol violation and is not checked.
- **Arithmetic:** plain 64-bit wraparound. Examples:
  - `0xFFFF_FFFF_FFFF_FFFF + 1 + 0` → sum 0, cout 1, ovf 0.
  - `0x7FFF_FFFF_FFFF_FFFF + 1` → sum `0x8000_0000_0000_0000`, cout 0, ovf 1.
- **FSM** (states are meaningful only with lock mode; otherwise always IDLE):
  - IDLE → LOCKED on a transfer with `req_last[g] = 0`.
  - LOCKED → IDLE on a transfer with `req_last = 1`.
- **In LOCKED:**
  - the grant is forced to the locked id;
  - the adder carry-in is the registered `chain_c`, which holds the cout of the previous beat;
  - `req_cin` is ignored.
- **Lock stall:** if the locked requester drops valid, the lock holds and no other requester is granted.

## Timing
- **Latency:** 1 cycle from transfer edge to `rsp_valid`.
- **Throughput:** 1 add per cycle while `rsp_ready` stays high.
- **Backpressure:** while `rsp_ready` is low and the slot is full, all `req_ready` are 0 and the response holds stable.
- **Reset values:**
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_ovf` = 0, `rsp_id` = 0;
  - `ptr` = `NREQ-1`, so requester 0 has first priority;
  - state = IDLE, `chain_c` = 0.
- **Reset mid-lock:** abandons the chain and returns to the reset values above; the next grant follows normal arbitration.
- **Single requester:** may be granted on consecutive cycles, since round-robin skips idle requesters.

## Configuration
- Macro: `CLA_ADD_ARB_LOCK_EN`.
- **Defined:** lock FSM, `chain_c` and `req_last` handling are compiled in, as described above.
- **Undefined:**
  - state is constant IDLE;
  - every beat uses its own `req_cin`;
  - `req_last` is accepted and ignored;
  - arbitration advances after every transfer.

## Structure
- Package `cla_pkg` holds:
  - `CLA_W = 64`;
  - the `cla_rsp_t` struct `{sum, cout, ovf, id}`;
  - the FSM state enum `{ARB_IDLE, ARB_LOCKED}`.
- Sub-module `cla_rr_arb`:
  - parameterised by `NREQ`;
  - inputs: request vector, `ptr`, lock enable, lock id;
  - output: one-hot grant plus encoded index;
  - purely combinational.
- Instantiates the existing `cla_64bit` once, with operand muxes driven by the grant.

## Test plan
- **Reset priority:** reset, all 4 requesters valid with `a = i`, `b = 1`, `rsp_ready = 1` → responses in id order 0,1,2,3,0, with sums 1,2,3,4; one per cycle.
- **Backpressure:** hold `rsp_ready = 0` for 5 cycles with a pending response → all `req_ready` are 0 and the response stays stable. Release → it drains, and the next grant is accepted in the same cycle.
- **Carry/overflow:** `a = 0xFFFF_FFFF_FFFF_FFFF`, `b = 0`, `cin = 1` → sum 0, cout 1, ovf 0. `a = 0x8000_0000_0000_0000`, `b = 0x8000_0000_0000_0000` → sum 0, cout 1, ovf 1.
- **Lock chaining** (`CLA_ADD_ARB_LOCK_EN`): requester 2 issues a 128-bit add.
  - Beat 1: low words `0xFFFF_FFFF_FFFF_FFFF + 1`, `last = 0`. Beat 2: high words `0 + 0`, `last = 1`.
  - Requester 1 is valid throughout.
  - Expected: responses (id 2, sum 0, cout 1), then (id 2, sum 1), then id 1.
- **Reset mid-lock:** assert `rst_n` low after beat 1 → `rsp_valid` is 0 and the state is IDLE. The next request from requester 1 uses its own `req_cin`.
- **Macro undefined:** same stimulus as lock chaining → the beat-2 sum is 0 (no carry chained), and requester 1 is served between the two beats.
